// File: rtl/otter_dec_pkg.sv
// Shared types for the OTTER decode-stage front end: immediate format codes,
// RV32I opcodes and the per-entry record held by the decode skid buffer.
package otter_dec_pkg;

    typedef enum logic [2:0] {
        FMT_NONE    = 3'd0,
        FMT_I       = 3'd1,
        FMT_S       = 3'd2,
        FMT_B       = 3'd3,
        FMT_U       = 3'd4,
        FMT_J       = 3'd5,
        FMT_ILLEGAL = 3'd7
    } imm_fmt_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] imm;
        imm_fmt_t    fmt;
        logic [31:0] tgt;
        logic        illegal;
    } entry_t;

    // Branches and jumps target PC+IMM; every other format falls through.
    function automatic logic is_pc_rel(input imm_fmt_t fmt);
        return (fmt == FMT_B) || (fmt == FMT_J);
    endfunction

endpackage

// File: rtl/otter_imm_fmt_decode.sv
// Combinational RV32I immediate-format classifier and immediate generator.
// OTTER_DEC_ILLEGAL_EN: unknown opcodes report FMT_ILLEGAL instead of FMT_NONE.
module otter_imm_fmt_decode
    import otter_dec_pkg::*;
(
    input  logic [31:0] ir,
    output imm_fmt_t    fmt,
    output logic [31:0] imm,
    output logic        illegal
);

    logic signed [31:0] imm_i;
    logic signed [31:0] imm_s;
    logic signed [31:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [31:0] imm_j;

    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u = {ir[31:12], 12'b0};
    assign imm_j = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};

    always_comb begin
        fmt     = FMT_NONE;
        imm     = '0;
        illegal = 1'b0;
        case (ir[6:0])
            OPC_LUI, OPC_AUIPC: begin
                fmt = FMT_U;
                imm = imm_u;
            end
            OPC_JAL: begin
                fmt = FMT_J;
                imm = imm_j;
            end
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM: begin
                fmt = FMT_I;
                imm = imm_i;
            end
            OPC_STORE: begin
                fmt = FMT_S;
                imm = imm_s;
            end
            OPC_BRANCH: begin
                fmt = FMT_B;
                imm = imm_b;
            end
            OPC_OP: begin
                fmt = FMT_NONE;
            end
            // Every legal opcode ends in 2'b11, so this arm also covers IR[1:0] != 2'b11.
            default: begin
`ifdef OTTER_DEC_ILLEGAL_EN
                fmt     = FMT_ILLEGAL;
                illegal = 1'b1;
`else
                fmt     = FMT_NONE;
                illegal = 1'b0;
`endif
            end
        endcase
    end

endmodule

// File: rtl/otter_imm_decode_stage.sv
// OTTER decode front end: classifies fetched instructions, registers immediate and
// target in a 2-entry skid buffer. OTTER_DEC_ILLEGAL_EN enables ID_ILLEGAL reporting.
module otter_imm_decode_stage
    import otter_dec_pkg::*;
#(
    parameter int unsigned PC_INC = 4,
    parameter int          XLEN   = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            FLUSH,
    input  logic            IF_VALID,
    output logic            IF_READY,
    input  logic [XLEN-1:0] IF_IR,
    input  logic [XLEN-1:0] IF_PC,
    output logic            ID_VALID,
    input  logic            ID_READY,
    output logic [XLEN-1:0] ID_IR,
    output logic [XLEN-1:0] ID_PC,
    output logic [XLEN-1:0] ID_IMM,
    output logic [2:0]      ID_FMT,
    output logic [XLEN-1:0] ID_TGT,
    output logic            ID_ILLEGAL
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        if_ready_q, if_ready_d;
    entry_t      head_q, head_d;
    entry_t      skid_q, skid_d;

    imm_fmt_t    dec_fmt;
    logic [31:0] dec_imm;
    logic        dec_illegal;
    logic [31:0] tgt_addend;
    entry_t      new_entry;
    logic        in_xfer;
    logic        out_xfer;

    otter_imm_fmt_decode u_fmt_decode (
        .ir      (IF_IR),
        .fmt     (dec_fmt),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    assign tgt_addend = is_pc_rel(dec_fmt) ? dec_imm : 32'(PC_INC);

    always_comb begin
        new_entry         = '0;
        new_entry.ir      = IF_IR;
        new_entry.pc      = IF_PC;
        new_entry.imm     = dec_imm;
        new_entry.fmt     = dec_fmt;
        new_entry.tgt     = IF_PC + tgt_addend;
        new_entry.illegal = dec_illegal;
    end

    assign in_xfer  = IF_VALID && if_ready_q;
    assign out_xfer = ID_VALID && ID_READY;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    head_d  = new_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_xfer && !out_xfer) begin
                    skid_d  = new_entry;
                    state_d = ST_FULL;
                end else if (in_xfer && out_xfer) begin
                    head_d  = new_entry;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // IF_READY is low here, so only the drain side can move.
                if (out_xfer) begin
                    head_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (FLUSH) begin
            state_d = ST_EMPTY;
        end
        if_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_EMPTY;
            if_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            if_ready_q <= if_ready_d;
        end
        head_q <= head_d;
        skid_q <= skid_d;
    end

    // Entry payloads are not reset; outputs are gated to zero while empty instead.
    assign IF_READY   = if_ready_q;
    assign ID_VALID   = (state_q != ST_EMPTY);
    assign ID_IR      = ID_VALID ? head_q.ir  : '0;
    assign ID_PC      = ID_VALID ? head_q.pc  : '0;
    assign ID_IMM     = ID_VALID ? head_q.imm : '0;
    assign ID_FMT     = ID_VALID ? head_q.fmt : 3'd0;
    assign ID_TGT     = ID_VALID ? head_q.tgt : '0;
    assign ID_ILLEGAL = ID_VALID && head_q.illegal;

endmodule

// File: tb/tb_otter_imm_decode_stage.sv
// Scoreboard bench for otter_imm_decode_stage: directed cases from the plan plus
// randomized traffic against a behavioural decode model.
module tb_otter_imm_decode_stage;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        FLUSH = 1'b0;
    logic        IF_VALID = 1'b0;
    logic        IF_READY;
    logic [31:0] IF_IR = '0;
    logic [31:0] IF_PC = '0;
    logic        ID_VALID;
    logic        ID_READY = 1'b0;
    logic [31:0] ID_IR;
    logic [31:0] ID_PC;
    logic [31:0] ID_IMM;
    logic [2:0]  ID_FMT;
    logic [31:0] ID_TGT;
    logic        ID_ILLEGAL;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic [31:0] tgt;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   occ = 0;
    bit   rst_last = 1'b1;
    bit   rand_rdy = 1'b0;

    otter_imm_decode_stage dut (
        .CLK        (CLK),
        .RST        (RST),
        .FLUSH      (FLUSH),
        .IF_VALID   (IF_VALID),
        .IF_READY   (IF_READY),
        .IF_IR      (IF_IR),
        .IF_PC      (IF_PC),
        .ID_VALID   (ID_VALID),
        .ID_READY   (ID_READY),
        .ID_IR      (ID_IR),
        .ID_PC      (ID_PC),
        .ID_IMM     (ID_IMM),
        .ID_FMT     (ID_FMT),
        .ID_TGT     (ID_TGT),
        .ID_ILLEGAL (ID_ILLEGAL)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Sign-extends an n-bit field using plain integer arithmetic.
    function automatic longint sx(input longint v, input int bits);
        return (v >= (longint'(1) << (bits - 1))) ? v - (longint'(1) << bits) : v;
    endfunction

    function automatic exp_t model(input logic [31:0] ir, input logic [31:0] pc);
        exp_t   e;
        longint w;
        longint v;
        w     = longint'(ir);
        v     = 0;
        e.ir  = ir;
        e.pc  = pc;
        e.fmt = 3'd0;
        e.ill = 1'b0;
        case (ir[6:0])
            7'h37, 7'h17: begin
                e.fmt = 3'd4;
                v = w - (w % 4096);
            end
            7'h6F: begin
                e.fmt = 3'd5;
                v = sx((((w >> 31) & 1) << 20) + (((w >> 12) & 255) << 12)
                     + (((w >> 20) & 1) << 11) + (((w >> 21) & 1023) << 1), 21);
            end
            7'h67, 7'h03, 7'h13, 7'h73: begin
                e.fmt = 3'd1;
                v = sx((w >> 20) & 4095, 12);
            end
            7'h23: begin
                e.fmt = 3'd2;
                v = sx((((w >> 25) & 127) << 5) + ((w >> 7) & 31), 12);
            end
            7'h63: begin
                e.fmt = 3'd3;
                v = sx((((w >> 31) & 1) << 12) + (((w >> 7) & 1) << 11)
                     + (((w >> 25) & 63) << 5) + (((w >> 8) & 15) << 1), 13);
            end
            7'h33: e.fmt = 3'd0;
            default: begin
`ifdef OTTER_DEC_ILLEGAL_EN
                e.fmt = 3'd7;
                e.ill = 1'b1;
`else
                e.fmt = 3'd0;
`endif
            end
        endcase
        e.imm = v[31:0];
        e.tgt = (e.fmt == 3'd3 || e.fmt == 3'd5) ? pc + e.imm : pc + 32'd4;
        return e;
    endfunction

    function automatic exp_t mk(input logic [31:0] ir, pc, imm, input logic [2:0] fmt,
                                input logic [31:0] tgt, input logic ill);
        exp_t e;
        e.ir = ir; e.pc = pc; e.imm = imm; e.fmt = fmt; e.tgt = tgt; e.ill = ill;
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send(input exp_t e);
        int waited = 0;
        IF_VALID = 1'b1;
        IF_IR    = e.ir;
        IF_PC    = e.pc;
        while (!IF_READY && waited < 64) begin
            @(posedge CLK);
            #1;
            waited++;
        end
        if (!IF_READY) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: IF_READY stayed 0 for ir 0x%08h", e.ir);
            IF_VALID = 1'b0;
        end else begin
            sb.push_back(e);
            @(posedge CLK);
            #1;
            IF_VALID = 1'b0;
        end
    endtask

    always @(posedge CLK) begin
        if (rand_rdy) begin
            #1;
            ID_READY = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: checks handshake flags against occupancy and the head against the scoreboard.
    always @(negedge CLK) begin
        bit   exp_vld;
        bit   exp_rdy;
        exp_t e;
        exp_vld = !rst_last && occ > 0;
        exp_rdy = !rst_last && occ < 2;
        chk("if_ready", 32'(IF_READY), 32'(exp_rdy));
        chk("id_valid", 32'(ID_VALID), 32'(exp_vld));
        if (!ID_VALID) begin
            chk("idle_outputs_zero", ID_IR | ID_PC | ID_IMM | ID_TGT
                | 32'(ID_FMT) | 32'(ID_ILLEGAL), 32'd0);
        end else if (!RST && !FLUSH) begin
            if (sb.size() == 0) begin
                chk("unexpected_output_ir", ID_IR, 32'hDEAD_0000 ^ ~ID_IR);
            end else begin
                e = sb[0];
                chk("head_ir", ID_IR, e.ir);
                chk("head_pc", ID_PC, e.pc);
                chk("head_imm", ID_IMM, e.imm);
                chk("head_fmt", 32'(ID_FMT), 32'(e.fmt));
                chk("head_tgt", ID_TGT, e.tgt);
                chk("head_illegal", 32'(ID_ILLEGAL), 32'(e.ill));
                if (ID_READY) void'(sb.pop_front());
            end
        end
        if (RST || FLUSH) occ = 0;
        else occ = occ + int'(IF_VALID && IF_READY) - int'(ID_VALID && ID_READY);
        rst_last = RST;
    end

    initial begin
        exp_t a;
        exp_t b;
        exp_t c;
        logic [31:0] r;
        logic [6:0]  opc;
        logic [6:0]  opcs [10];
        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h73, 7'h23, 7'h63, 7'h33};

        // Reset held for three cycles
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        ID_READY = 1'b1;
        @(posedge CLK);
        #1;

        // Directed decode cases
        send(mk(32'hFE000EE3, 32'h0000_0100, 32'hFFFF_FFFC, 3'd3, 32'h0000_00FC, 1'b0));
        send(mk(32'h123450B7, 32'h0000_0200, 32'h1234_5000, 3'd4, 32'h0000_0204, 1'b0));
        send(mk(32'h008000EF, 32'hFFFF_FFFC, 32'h0000_0008, 3'd5, 32'h0000_0004, 1'b0));
`ifdef OTTER_DEC_ILLEGAL_EN
        send(mk(32'h0000007F, 32'h0000_0300, 32'h0, 3'd7, 32'h0000_0304, 1'b1));
`else
        send(mk(32'h0000007F, 32'h0000_0300, 32'h0, 3'd0, 32'h0000_0304, 1'b0));
`endif
        repeat (3) @(posedge CLK);
        #1;

        // Backpressure: A and B fill the buffer, C is held until the consumer drains
        ID_READY = 1'b0;
        a = model(32'h00A00093, 32'h0000_1000);
        b = model(32'h00112223, 32'h0000_1004);
        c = model(32'hFE209CE3, 32'h0000_1008);
        send(a);
        send(b);
        fork
            send(c);
            begin
                repeat (4) @(posedge CLK);
                #1;
                ID_READY = 1'b1;
            end
        join
        repeat (4) @(posedge CLK);
        #1;

        // Flush with the buffer full and a third instruction on the input
        ID_READY = 1'b0;
        send(model(32'h00500113, 32'h0000_2000));
        send(model(32'h0040006F, 32'h0000_2004));
        IF_VALID = 1'b1;
        IF_IR    = 32'h00000537;
        IF_PC    = 32'h0000_2008;
        FLUSH    = 1'b1;
        sb.delete();
        @(posedge CLK);
        #1;
        FLUSH    = 1'b0;
        IF_VALID = 1'b0;
        ID_READY = 1'b1;
        repeat (4) @(posedge CLK);
        #1;

        // Reset in mid-operation drops both entries
        ID_READY = 1'b0;
        send(model(32'h00000013, 32'h0000_3000));
        send(model(32'h00000067, 32'h0000_3004));
        RST = 1'b1;
        sb.delete();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        ID_READY = 1'b1;
        repeat (3) @(posedge CLK);
        #1;

        // Randomized traffic with random consumer backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            r   = $urandom();
            opc = (i % 12 < 10) ? opcs[i % 12] : ((i % 12 == 10) ? 7'($urandom()) : 7'h7F);
            r[6:0] = opc;
            send(model(r, $urandom() & 32'hFFFF_FFFC | ((i % 7 == 0) ? 32'hFFFF_FF00 : 32'h0)));
            repeat ($urandom_range(0, 2)) @(posedge CLK);
            #1;
        end

        // Drain
        rand_rdy = 1'b0;
        @(posedge CLK);
        #2;
        ID_READY = 1'b1;
        for (int i = 0; i < 100 && sb.size() > 0; i++) @(posedge CLK);
        if (sb.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d entries still expected, required 0", sb.size());
        end
        repeat (3) @(posedge CLK);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
